// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial 32-bit ALU, one 1-bit slice per clock, LSB first.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   start_i     operation request, sampled only while ready_o=1
//   src1_i      operand A
//   src2_i      operand B
//   ctrl_i      {A_invert, B_invert, operation[1:0]}
//                 op 00 AND, 01 OR, 10 ADD, 11 SLT (NOR=1100, SUB=0110, SLT=0111)
//   ready_o     idle, a start will be accepted
//   done_o      one-cycle pulse, result outputs valid
//   result_o    result
//   zero_o      result_o == 0 (combinational on the registered result)
//   cout_o      carry out of bit 31 (ADD family only)
//   overflow_o  signed overflow (ADD family only)
//
// Configuration
//   ALU_SERIAL_FASTLOGIC_EN  when defined, AND/OR operations are computed in
//                            parallel on the accept edge and skip RUN.

module alu_serial_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [3:0]  ctrl_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        cout_o,
  output logic        overflow_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   result_d;
  logic                cout_d, ovf_d;
  logic                ready_d, done_d;

  // Current bit slice
  logic ai, bi, sum_bit, carry_out, slice_bit;
  logic last_bit;

`ifdef ALU_SERIAL_FASTLOGIC_EN
  logic [DATA_W-1:0] fast_a, fast_b, fast_result;

  // Parallel AND/OR straight from the inputs on the accept edge
  always_comb begin
    fast_a      = src1_i ^ {DATA_W{ctrl_i[3]}};
    fast_b      = src2_i ^ {DATA_W{ctrl_i[2]}};
    fast_result = (ctrl_i[1:0] == OP_AND) ? (fast_a & fast_b) : (fast_a | fast_b);
  end
`endif

  // One-bit slice of the latched operands at the current counter position
  always_comb begin
    ai        = a_q[cnt_q] ^ ctrl_q[3];
    bi        = b_q[cnt_q] ^ ctrl_q[2];
    sum_bit   = ai ^ bi ^ carry_q;
    carry_out = (ai & bi) | (ai & carry_q) | (bi & carry_q);
    last_bit  = (cnt_q == CNT_W'(DATA_W - 1));
    case (ctrl_q[1:0])
      OP_AND:  slice_bit = ai & bi;
      OP_OR:   slice_bit = ai | bi;
      OP_ADD:  slice_bit = sum_bit;
      default: slice_bit = 1'b0;  // SLT: upper bits zero, bit 0 patched at the end
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    result_d = result_o;
    cout_d   = cout_o;
    ovf_d    = overflow_o;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = src1_i;
          b_d     = src2_i;
          ctrl_d  = ctrl_i;
          cnt_d   = '0;
          carry_d = ctrl_i[2];  // B_invert doubles as carry-in for subtraction
          state_d = RUN;
`ifdef ALU_SERIAL_FASTLOGIC_EN
          if (!ctrl_i[1]) begin
            result_d = fast_result;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end
`endif
        end
      end

      RUN: begin
        // Shift in from the top so bit 0 ends at the LSB after 32 slices
        result_d = {slice_bit, result_o[DATA_W-1:1]};
        carry_d  = carry_out;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          if (ctrl_q[1:0] == OP_ADD) begin
            cout_d = carry_out;
            ovf_d  = (ai & bi & ~sum_bit) | (~ai & ~bi & sum_bit);
          end else begin
            cout_d = 1'b0;
            ovf_d  = 1'b0;
          end
          // SLT: set = raw sign of A-B, no overflow correction
          if (ctrl_q[1:0] == OP_SLT) begin
            result_d = {{(DATA_W - 1){1'b0}}, sum_bit};
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      result_o   <= '0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      result_o   <= result_d;
      cout_o     <= cout_d;
      overflow_o <= ovf_d;
      ready_o    <= ready_d;
      done_o     <= done_d;
    end
  end

  assign zero_o = (result_o == '0);

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk_i, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1 bit: operation request, sampled only while ready_o=1.
REQ-005 SHALL have port src1_i, input, 32 bits: operand A.
REQ-006 SHALL have port src2_i, input, 32 bits: operand B.
REQ-007 SHALL have port ctrl_i, input, 4 bits: {A_invert, B_invert, operation[1:0]}.
REQ-008 SHALL have port ready_o, output, 1 bit: idle, start accepted.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse, outputs valid.
REQ-010 SHALL have port result_o, output, 32 bits: result.
REQ-011 SHALL have port zero_o, output, 1 bit: result_o==0.
REQ-012 SHALL have port cout_o, output, 1 bit: carry out of bit 31.
REQ-013 SHALL have port overflow_o, output, 1 bit: signed overflow.

Function
REQ-014 SHALL run a bit-serial 32-bit ALU that evaluates one 1-bit slice per cycle, LSB first, with the carry held in a register between bits.
REQ-015 SHALL use three FSM states: IDLE, RUN and DONE; ready_o=1 only in IDLE.
REQ-016 SHALL, in IDLE with start_i=1, on that edge latch src1_i, src2_i and ctrl_i, clear the bit counter, load carry=ctrl_i[2] (B_invert), and go to RUN.
REQ-017 SHALL, in RUN, on each edge compute bit i from Ai=src1[i]^A_invert, Bi=src2[i]^B_invert and carry, shift it into the result register, update carry, and increment the counter.
REQ-018 SHALL, per operation: 00 gives Ai&Bi; 01 gives Ai|Bi; 10 gives Ai^Bi^carry; 11 (SLT) gives 0 for bits 1..31 and set for bit 0, where set = sum bit 31 (no overflow correction).
REQ-019 SHALL go from RUN to DONE on the edge that processes bit 31; that is 32 edges after the accept edge.
REQ-020 SHALL hold done_o=1 for exactly the one DONE cycle, then return to IDLE on the next edge.
REQ-021 SHALL, for operation 10, set cout_o to the bit-31 carry out and overflow_o=(A31&B31&~S31)|(~A31&~B31&S31); for other operations both are 0.
REQ-022 SHALL make zero_o combinational on the registered result_o.
REQ-023 SHALL hold result_o, zero_o, cout_o and overflow_o stable from DONE until the next accepted start; they are undefined while in RUN.
REQ-024 SHALL ignore start_i in RUN and DONE; there is no queuing.
REQ-025 SHALL make all 16 ctrl_i codes legal, decoded per field; NOR=1100, SUB=0110, SLT=0111.

Reset
REQ-026 SHALL, on rst_i=1 at a clock edge: state=IDLE, ready_o=1, done_o=0, result_o=0, zero_o=1, cout_o=0, overflow_o=0, counter=0, carry=0.
REQ-027 SHALL give reset priority over start_i; reset mid-RUN or mid-DONE aborts with no done_o pulse.

Configuration
REQ-028 SHALL support macro ALU_SERIAL_FASTLOGIC_EN; when it is defined, operations 00/01 skip RUN, compute all 32 bits in parallel on the accept edge, enter DONE directly, and pulse done_o 1 cycle after accept.
REQ-029 SHALL, when ALU_SERIAL_FASTLOGIC_EN is undefined, take 32 RUN cycles for every operation.

Verification
REQ-030 SHALL cover ADD: src1=0x7FFFFFFF, src2=0x00000001, ctrl=0010 -> done_o 32 cycles after accept, result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0.
REQ-031 SHALL cover SUB: src1=5, src2=5, ctrl=0110 -> result_o=0, zero_o=1, cout_o=1, overflow_o=0.
REQ-032 SHALL cover SLT: ctrl=0111 with 3 vs 7 -> result_o=0x00000001; with 7 vs 3 -> 0x00000000.
REQ-033 SHALL cover NOR: src1=0xF0F0F0F0, src2=0x0F0F0F00, ctrl=1100 -> result_o=0x0000000F; done_o latency 1 cycle with ALU_SERIAL_FASTLOGIC_EN and 32 cycles without.
REQ-034 SHALL cover start_i pulsed during RUN -> ignored, and result_o unchanged from the first operation's result.
REQ-035 SHALL cover rst_i=1 at RUN cycle 10 -> next cycle ready_o=1, result_o=0, no done_o pulse.
